// File: rtl/branch_pkg.sv
// branch_pkg
//   Shared definitions for the EX-stage branch unit:
//   - funct3 encodings of the six RV conditional branches
//   - 2-bit saturating counter states used by the branch history table
//   - next_cnt(): counter update for a resolved branch outcome
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_state_t;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic cnt_state_t next_cnt(input cnt_state_t cur, input logic tk);
    cnt_state_t nxt;
    case (cur)
      CNT_SNT: nxt = tk ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = tk ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = tk ? CNT_ST  : CNT_WNT;
      default: nxt = tk ? CNT_ST  : CNT_WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// branch_compare
//   Combinational evaluation of an RV branch condition.
//   Ports:
//     funct3  in   3     branch funct3
//     a       in   XLEN  rs1 value
//     b       in   XLEN  rs2 value
//     cond    out  1     branch condition holds (0 for illegal encodings)
//     illegal out  1     funct3 is 010 or 011
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond,
  output logic            illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (a == b);
      F3_BNE:  cond = (a != b);
      F3_BLT:  cond = ($signed(a) <  $signed(b));
      F3_BGE:  cond = ($signed(a) >= $signed(b));
      F3_BLTU: cond = (a <  b);
      F3_BGEU: cond = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit
//   EX-stage branch resolution for the RV64 pipeline. Resolves the branch,
//   registers outcome/target/mispredict for the front end and maintains a
//   direct-mapped BHT of 2-bit saturating counters that IF reads.
//   Optional feature macro: BRANCH_STATS_EN (resolve/mispredict counters).
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     ex_valid          valid branch in EX this cycle
//     funct3            branch funct3
//     readData1, b      rs1 / rs2 values
//     ex_pc, imm        branch PC and sign-extended B-immediate
//     ex_pred_taken     prediction made in IF for this branch
//     if_pc             fetch PC for BHT lookup
//     if_pred_taken     combinational BHT prediction for if_pc
//     resolve_valid     registered one-cycle pulse per ex_valid
//     taken             registered outcome
//     mispredict        registered outcome != prediction
//     redirect_pc       registered correct next PC (holds when idle)
//     illegal_funct3    registered illegal-encoding flag
//     stat_branches     legal resolve count (0 when stats disabled)
//     stat_mispredicts  legal mispredict count (0 when stats disabled)
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  readData1,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic             resolve_valid,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_funct3,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  cnt_state_t bht [BHT_DEPTH];

  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic             cond;
  logic             illegal;
  logic             legal_resolve;
  logic             misp_next;
  logic [XLEN-1:0]  target;
  cnt_state_t       if_cnt;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_idx = if_pc[IDX_W+1:2];

  branch_compare #(.XLEN(XLEN)) u_compare (
    .funct3  (funct3),
    .a       (readData1),
    .b       (b),
    .cond    (cond),
    .illegal (illegal)
  );

  // cond is forced low for illegal encodings, so an illegal branch falls
  // through to pc+4 and reports mispredict exactly when IF predicted taken.
  assign legal_resolve = ex_valid & ~illegal;
  assign misp_next     = cond ^ ex_pred_taken;
  assign target        = cond ? (ex_pc + imm) : (ex_pc + XLEN'(4));

  // Array read is from the registered table, so a same-cycle update of the
  // looked-up entry is seen by IF only on the following cycle.
  assign if_cnt        = bht[if_idx];
  assign if_pred_taken = if_cnt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CNT_WNT;
      end
      resolve_valid  <= 1'b0;
      taken          <= 1'b0;
      mispredict     <= 1'b0;
      illegal_funct3 <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      resolve_valid  <= ex_valid;
      taken          <= ex_valid & cond;
      mispredict     <= ex_valid & misp_next;
      illegal_funct3 <= ex_valid & illegal;
      if (ex_valid) begin
        redirect_pc <= target;
      end
      if (legal_resolve) begin
        bht[ex_idx] <= next_cnt(bht[ex_idx], cond);
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] misp_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= '0;
      misp_cnt   <= '0;
    end else if (legal_resolve) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (misp_next && (misp_cnt != '1)) begin
        misp_cnt <= misp_cnt + CNT_W'(1);
      end
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = misp_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

  // Fetch PC bits outside the index field do not take part in the lookup.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

endmodule
